// File: rtl/dct_pkg.sv
// Shared definitions for the DCT zigzag serializer: block geometry, FSM states
// and the JPEG zigzag scan table (zigzag position -> row-major address r*8+c).
// No logic lives here; the table is consumed by dct_zigzag_lut.
package dct_pkg;

  // Coefficient block is DCT_N x DCT_N
  localparam int DCT_N  = 8;
  localparam int ZZ_LEN = DCT_N * DCT_N;

  // Final zigzag position of a block
  localparam logic [5:0] ZZ_LAST_POS = 6'd63;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Standard JPEG zigzag order: entry p holds the row-major address of the
  // coefficient emitted at zigzag position p.
  localparam logic [5:0] ZIGZAG [ZZ_LEN] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zigzag_addr(input logic [5:0] pos);
    return ZIGZAG[pos];
  endfunction

endpackage

// File: rtl/dct_zigzag_lut.sv
// Purpose: zigzag position -> row-major coefficient address lookup.
// Latency: combinational. Backpressure: none (pure function).
// Ports: i_pos  - zigzag position 0..63
//        o_addr - row-major address r*8+c (row in [5:3], column in [2:0])
module dct_zigzag_lut
  import dct_pkg::*;
(
  input  logic [5:0] i_pos,
  output logic [5:0] o_addr
);

  assign o_addr = zigzag_addr(i_pos);

endmodule

// File: rtl/dct_zigzag_serializer.sv
// Purpose: capture an 8x8 DCT coefficient block on a rising IN_ENABLE edge and
//          stream it out one word per transfer in JPEG zigzag order.
// Latency: first coefficient valid the cycle after the block start; back-to-back
//          blocks stream without a bubble if the start lines up with position 63.
// Backpressure: OUT_READY stalls the stream with outputs held; upstream is never
//          stalled -- a start that cannot be captured is dropped and OVERFLOW sticks.
// Ports: CLOCK/RESET (async active-low), IN_ENABLE + IN_DATA[row][col] from the
//        DCT stage, OUT_VALID/OUT_READY/OUT_DATA/OUT_INDEX/OUT_LAST stream,
//        BUSY (block held), OVERFLOW (sticky dropped-start flag).
module dct_zigzag_serializer
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                                          CLOCK,
  input  logic                                          RESET,
  input  logic                                          IN_ENABLE,
  input  logic [DCT_N-1:0][DCT_N-1:0][DATA_WIDTH-1:0]   IN_DATA,
  output logic                                          OUT_VALID,
  input  logic                                          OUT_READY,
  output logic [DATA_WIDTH-1:0]                         OUT_DATA,
  output logic [5:0]                                    OUT_INDEX,
  output logic                                          OUT_LAST,
  output logic                                          BUSY,
  output logic                                          OVERFLOW
);

  state_t r_state;
  state_t w_state_nxt;

  logic       r_enable_q;
  logic [5:0] r_index;
  logic [5:0] w_index_nxt;
  logic       r_overflow;

  // Single-block storage; deliberately not reset (data only, gated by state)
  logic [DCT_N-1:0][DCT_N-1:0][DATA_WIDTH-1:0] r_buf;

  logic       w_send;
  logic       w_start;
  logic       w_xfer;
  logic       w_last_xfer;
  logic       w_capture;
  logic [5:0] w_addr;

  assign w_send      = (r_state == ST_SEND);
  assign w_start     = IN_ENABLE & ~r_enable_q;
  assign w_xfer      = w_send & OUT_READY;
  assign w_last_xfer = w_xfer & (r_index == ZZ_LAST_POS);
  // The buffer is free either when idle or when its last word leaves this cycle
  assign w_capture   = w_start & (~w_send | w_last_xfer);

  // Next-state / next-index logic
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    if (w_capture) begin
      w_state_nxt = ST_SEND;
      w_index_nxt = 6'd0;
    end else if (w_last_xfer) begin
      w_state_nxt = ST_IDLE;
      w_index_nxt = 6'd0;
    end else if (w_xfer) begin
      w_index_nxt = r_index + 6'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_enable_q <= 1'b0;
      r_index    <= 6'd0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_enable_q <= IN_ENABLE;
      r_index    <= w_index_nxt;
      if (w_start && !w_capture) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (w_capture) begin
      r_buf <= IN_DATA;
    end
  end

  dct_zigzag_lut u_lut (
    .i_pos  (r_index),
    .o_addr (w_addr)
  );

  // Outputs are decoded from registered state only, so reset clears
  // OUT_VALID/OUT_LAST/BUSY immediately without waiting for a clock.
  assign OUT_VALID = w_send;
  assign OUT_INDEX = r_index;
  assign OUT_LAST  = w_send & (r_index == ZZ_LAST_POS);
  assign OUT_DATA  = r_buf[w_addr[5:3]][w_addr[2:0]];
  assign BUSY      = w_send;
  assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_dct_zigzag_serializer.sv
module tb_dct_zigzag_serializer;

  localparam int DW = 32;
  typedef logic [DW-1:0] word_t;
  typedef logic [7:0][7:0][DW-1:0] blk_t;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       IN_ENABLE = 1'b0;
  blk_t       IN_DATA;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  word_t      OUT_DATA;
  logic [5:0] OUT_INDEX;
  logic       OUT_LAST;
  logic       BUSY;
  logic       OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected output stream of the current block, in zigzag order
  word_t exp_s [64];

  dct_zigzag_serializer #(.DATA_WIDTH(DW)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .IN_ENABLE (IN_ENABLE),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .OUT_INDEX (OUT_INDEX),
    .OUT_LAST  (OUT_LAST),
    .BUSY      (BUSY),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: walk the anti-diagonals s=r+c; even diagonals run bottom-left
  // to top-right (row decreasing), odd ones top-right to bottom-left.
  task automatic build_expected(input blk_t b);
    int p;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      int lo;
      int hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          exp_s[p] = b[r][s-r];
          p++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          exp_s[p] = b[r][s-r];
          p++;
        end
      end
    end
  endtask

  task automatic rand_block(output blk_t b);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = $urandom;
  endtask

  task automatic seq_block(input int base, output blk_t b);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = word_t'(base + r * 8 + c);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    IN_DATA   = '0;
    IN_ENABLE = 1'b0;
    OUT_READY = 1'b0;
    #1 RESET = 1'b0;
    #1;
    n_tests++;
    if ({OUT_VALID, OUT_LAST, BUSY, OVERFLOW, OUT_INDEX} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_async: got v/l/b/o/idx=%b required 0000000000",
               {OUT_VALID, OUT_LAST, BUSY, OVERFLOW, OUT_INDEX});
    end
    tick();
    tick();
    n_tests++;
    if ({OUT_VALID, OUT_LAST, BUSY, OVERFLOW, OUT_INDEX} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_held: got v/l/b/o/idx=%b required 0000000000",
               {OUT_VALID, OUT_LAST, BUSY, OVERFLOW, OUT_INDEX});
    end
    #2 RESET = 1'b1;
    tick();
    n_tests++;
    if ({OUT_VALID, BUSY, OVERFLOW} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got v/b/o=%b required 000", {OUT_VALID, BUSY, OVERFLOW});
    end
  endtask

  task automatic test_sequential();
    blk_t blk;
    seq_block(0, blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b1;
    IN_ENABLE = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, BUSY, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 1'b1, 6'(k), (k == 63), exp_s[k]}) begin
        n_fail++;
        $display("FAIL seq_beat k=%0d: got v=%b b=%b idx=%0d last=%b data=%0d required v=1 b=1 idx=%0d last=%b data=%0d",
                 k, OUT_VALID, BUSY, OUT_INDEX, OUT_LAST, OUT_DATA, k, (k == 63), exp_s[k]);
      end
      tick();
    end
    n_tests++;
    if ({OUT_VALID, BUSY, OVERFLOW, OUT_LAST} !== 4'b0000) begin
      n_fail++;
      $display("FAIL seq_idle_after: got v/b/o/l=%b required 0000", {OUT_VALID, BUSY, OVERFLOW, OUT_LAST});
    end
    IN_ENABLE = 1'b0;
    tick();
  endtask

  task automatic test_random_stall();
    blk_t blk;
    int got;
    int cyc;
    bit stalled;
    bit pat [4];
    logic [DW+6:0] prev;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    prev = '0;
    rand_block(blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b0;
    IN_ENABLE = 1'b1;
    tick();
    IN_ENABLE = 1'b0;
    while (got < 64 && cyc < 2000) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 6'(got), (got == 63), exp_s[got]}) begin
        n_fail++;
        $display("FAIL stall_beat n=%0d: got v=%b idx=%0d last=%b data=%h required v=1 idx=%0d last=%b data=%h",
                 got, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, got, (got == 63), exp_s[got]);
      end
      if (stalled) begin
        n_tests++;
        if ({OUT_INDEX, OUT_LAST, OUT_DATA} !== prev) begin
          n_fail++;
          $display("FAIL stall_hold n=%0d: got %h required held %h", got, {OUT_INDEX, OUT_LAST, OUT_DATA}, prev);
        end
      end
      prev = {OUT_INDEX, OUT_LAST, OUT_DATA};
      OUT_READY = (cyc < 4) ? pat[cyc] : 1'($urandom_range(0, 1));
      stalled = !OUT_READY;
      if (OUT_READY) got++;
      cyc++;
      tick();
    end
    n_tests++;
    if (got != 64) begin
      n_fail++;
      $display("FAIL stall_budget: got %0d transfers required 64", got);
    end
    n_tests++;
    if ({OUT_VALID, BUSY} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_idle_after: got v/b=%b required 00", {OUT_VALID, BUSY});
    end
    OUT_READY = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    blk_t blk;
    seq_block(0, blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b1;
    IN_ENABLE = 1'b1;
    tick();
    IN_ENABLE = 1'b0;
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 6'(k), (k == 63), exp_s[k]}) begin
        n_fail++;
        $display("FAIL b2b_a k=%0d: got v=%b idx=%0d last=%b data=%0d required v=1 idx=%0d data=%0d",
                 k, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, k, exp_s[k]);
      end
      if (k == 63) begin
        // Rising edge lands on the same clock as the position-63 transfer
        seq_block(100, blk);
        IN_DATA   = blk;
        IN_ENABLE = 1'b1;
      end
      tick();
    end
    build_expected(blk);
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, OVERFLOW} !== {1'b1, 6'(k), (k == 63), exp_s[k], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_b k=%0d: got v=%b idx=%0d last=%b data=%0d ovf=%b required v=1 idx=%0d data=%0d ovf=0",
                 k, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, OVERFLOW, k, exp_s[k]);
      end
      tick();
    end
    n_tests++;
    if ({OUT_VALID, BUSY, OVERFLOW} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got v/b/o=%b required 000", {OUT_VALID, BUSY, OVERFLOW});
    end
    IN_ENABLE = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    blk_t blk;
    blk_t blk2;
    rand_block(blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b1;
    IN_ENABLE = 1'b1;
    tick();
    IN_ENABLE = 1'b0;
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 6'(k), (k == 63), exp_s[k]}) begin
        n_fail++;
        $display("FAIL ovf_a k=%0d: got v=%b idx=%0d last=%b data=%h required v=1 idx=%0d data=%h",
                 k, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, k, exp_s[k]);
      end
      if (k == 10 || k == 11) begin
        n_tests++;
        if (OVERFLOW !== (k == 11)) begin
          n_fail++;
          $display("FAIL ovf_flag k=%0d: got %b required %b", k, OVERFLOW, (k == 11));
        end
      end
      if (k == 10) begin
        rand_block(blk2);
        IN_DATA   = blk2;
        IN_ENABLE = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({OUT_VALID, BUSY, OVERFLOW} !== 3'b001) begin
        n_fail++;
        $display("FAIL ovf_no_block_b i=%0d: got v/b/o=%b required 001", i, {OUT_VALID, BUSY, OVERFLOW});
      end
      tick();
    end
    IN_ENABLE = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_block();
    blk_t blk;
    rand_block(blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b1;
    IN_ENABLE = 1'b1;
    tick();
    IN_ENABLE = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_DATA} !== {1'b1, 6'(k), exp_s[k]}) begin
        n_fail++;
        $display("FAIL rst_pre k=%0d: got v=%b idx=%0d data=%h required v=1 idx=%0d data=%h",
                 k, OUT_VALID, OUT_INDEX, OUT_DATA, k, exp_s[k]);
      end
      if (k < 30) tick();
    end
    // Mid-cycle, well away from any clock edge
    #2 RESET = 1'b0;
    #1;
    n_tests++;
    if ({OUT_VALID, BUSY, OUT_LAST, OVERFLOW} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_async_mid: got v/b/l/o=%b required 0000", {OUT_VALID, BUSY, OUT_LAST, OVERFLOW});
    end
    tick();
    tick();
    #2 RESET = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({OUT_VALID, BUSY} !== 2'b00) begin
        n_fail++;
        $display("FAIL rst_no_output i=%0d: got v/b=%b required 00", i, {OUT_VALID, BUSY});
      end
      tick();
    end
    rand_block(blk);
    build_expected(blk);
    IN_DATA   = blk;
    IN_ENABLE = 1'b1;
    tick();
    IN_ENABLE = 1'b0;
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 6'(k), (k == 63), exp_s[k]}) begin
        n_fail++;
        $display("FAIL rst_new_block k=%0d: got v=%b idx=%0d last=%b data=%h required v=1 idx=%0d data=%h",
                 k, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, k, exp_s[k]);
      end
      tick();
    end
  endtask

  task automatic test_enable_across_reset();
    blk_t blk;
    #2 RESET = 1'b0;
    rand_block(blk);
    build_expected(blk);
    IN_DATA   = blk;
    OUT_READY = 1'b1;
    IN_ENABLE = 1'b1;
    tick();
    tick();
    #2 RESET = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      n_tests++;
      if ({OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA} !== {1'b1, 6'(k), (k == 63), exp_s[k]}) begin
        n_fail++;
        $display("FAIL rel_beat k=%0d: got v=%b idx=%0d last=%b data=%h required v=1 idx=%0d data=%h",
                 k, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_DATA, k, exp_s[k]);
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if ({OUT_VALID, BUSY, OVERFLOW} !== 3'b000) begin
        n_fail++;
        $display("FAIL rel_no_repeat i=%0d: got v/b/o=%b required 000", i, {OUT_VALID, BUSY, OVERFLOW});
      end
      tick();
    end
    IN_ENABLE = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_random_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid_block();
    test_enable_across_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_zigzag_serializer.md
DCT_ZIGZAG_SERIALIZER -- requirements
Module: dct_zigzag_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the coefficient word width.
REQ-002 SHALL have port CLOCK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port IN_ENABLE, input, 1 bit: the 2-D DCT stage's output-enable level, which stays high once asserted.
REQ-005 SHALL have port IN_DATA, input, [8][8] x DATA_WIDTH: the 2-D DCT coefficient block, indexed [row][col].
REQ-006 SHALL have port OUT_VALID, output, 1 bit: OUT_DATA holds a valid coefficient.
REQ-007 SHALL have port OUT_READY, input, 1 bit: the downstream consumer accepts a coefficient.
REQ-008 SHALL have port OUT_DATA, output, DATA_WIDTH: the current coefficient in zigzag order.
REQ-009 SHALL have port OUT_INDEX, output, 6 bits: the zigzag position (0..63) of OUT_DATA.
REQ-010 SHALL have port OUT_LAST, output, 1 bit: high with position 63.
REQ-011 SHALL have port BUSY, output, 1 bit: a block is held and not fully sent.
REQ-012 SHALL have port OVERFLOW, output, 1 bit: sticky flag, a block start was dropped.

Function
REQ-013 SHALL register IN_ENABLE into enable_q each cycle; a block start is the condition IN_ENABLE=1 and enable_q=0.
REQ-014 SHALL use an FSM with two states, IDLE and SEND, and leave reset in IDLE.
REQ-015 SHALL capture all 64 words of IN_DATA into an internal buffer on a block start if in IDLE, or if in SEND with the index-63 transfer occurring that same cycle.
REQ-016 SHALL move to SEND on a capture, so that OUT_VALID=1 with OUT_INDEX=0 in the cycle after the block start (1-cycle latency).
REQ-017 SHALL treat OUT_VALID=1 and OUT_READY=1 as a transfer, and SHALL advance OUT_INDEX by one on each transfer.
REQ-018 SHALL hold OUT_DATA, OUT_INDEX and OUT_LAST stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 SHALL never deassert OUT_VALID in SEND before the index-63 transfer completes.
REQ-020 SHALL set OUT_DATA = buffer[r][c], where zigzag position p maps to r*8+c via the standard JPEG zigzag table (0,1,8,16,9,2,3,10,17,24,...,55,62,63).
REQ-021 SHALL, on the index-63 transfer with no simultaneous capture, go to IDLE with OUT_VALID=0 the next cycle.
REQ-022 SHALL, on the index-63 transfer with a simultaneous capture, stay in SEND with OUT_INDEX=0 of the new block the next cycle (no bubble).
REQ-023 SHALL, on a block start that is not captured, set OVERFLOW=1 and leave the buffer and index unchanged.
REQ-024 SHALL keep OVERFLOW set until reset.
REQ-025 SHALL drive BUSY=1 exactly when the state is SEND.
REQ-026 SHALL not buffer a second block (single-block storage), and SHALL never generate backpressure upstream.
REQ-027 SHALL pass data unmodified, with no arithmetic, at DATA_WIDTH bits.

Reset
REQ-028 SHALL, with RESET=0 and independently of CLOCK, clear state to IDLE, enable_q to 0, index to 0, and set OUT_VALID=0, OUT_LAST=0, BUSY=0, OVERFLOW=0.
REQ-029 SHALL leave OUT_DATA unspecified during reset, since the buffer is not cleared.
REQ-030 SHALL abort a block in progress when reset is asserted mid-block, with no further output for that block.
REQ-031 SHALL capture on the first clock edge after reset release if IN_ENABLE=1 at release.

Structure
REQ-032 SHALL take DCT_N=8, the zigzag table (64 x 6-bit), and the state enum from shared package dct_pkg.
REQ-033 SHALL place the zigzag lookup in one sub-module, dct_zigzag_lut (combinational, 6-bit position in, 6-bit row-major address out).

Verification
REQ-034 SHALL cover: IN_DATA[r][c]=r*8+c, a rising edge on IN_ENABLE, OUT_READY held 1 -> OUT_DATA 0,1,8,16,9,2,3,10,... in 64 consecutive cycles, OUT_LAST only with value 63, BUSY low afterwards.
REQ-035 SHALL cover: OUT_READY toggling 1,0,0,1 randomly -> no value skipped or repeated, outputs stable in stall cycles, 64 transfers total.
REQ-036 SHALL cover: a second rising edge (block B = 100+r*8+c) aligned with the index-63 transfer of block A -> next cycle OUT_INDEX=0 with OUT_DATA=100, OVERFLOW stays 0.
REQ-037 SHALL cover: a second rising edge at index 10 of block A -> OVERFLOW=1, block A completes unchanged, no block B output.
REQ-038 SHALL cover: RESET pulled low at index 30 -> OUT_VALID=0 immediately (asynchronously), BUSY=0, no output after release until a new rising edge.
REQ-039 SHALL cover: IN_ENABLE held high across reset release -> one capture and one 64-word block, then idle with no repeat.
